// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer: animation mode encoding and its advance order.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_CHASE   = 2'd3
  } mode_e;

  function automatic mode_e next_mode(input mode_e cur);
    case (cur)
      MODE_OFF:     next_mode = MODE_BLINK;
      MODE_BLINK:   next_mode = MODE_BREATHE;
      MODE_BREATHE: next_mode = MODE_CHASE;
      default:      next_mode = MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_pwm_sequencer_debounce.sv
// Button conditioner: 2-flop synchroniser plus a down-counting stability timer.
module button_debounce
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic clki,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_state,
  output logic press
);

  localparam logic [DEBOUNCE_BITS-1:0] DB_RELOAD = '1;

  logic                     sync_q1;
  logic                     sync_q2;
  logic [DEBOUNCE_BITS-1:0] db_cnt;
  logic                     differ;
  logic                     db_done;

  // Terminal count reached on the 2**DEBOUNCE_BITS-th consecutive differing cycle.
  assign differ  = (sync_q2 != btn_state);
  assign db_done = differ && (db_cnt == '0);

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1   <= 1'b1;
      sync_q2   <= 1'b1;
      btn_state <= 1'b1;
      db_cnt    <= DB_RELOAD;
      press     <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      press   <= db_done && !sync_q2;
      if (!differ || db_done)
        db_cnt <= DB_RELOAD;
      else
        db_cnt <= db_cnt - 1'b1;
      if (db_done)
        btn_state <= sync_q2;
    end
  end

endmodule

// File: rtl/led_pwm_sequencer.sv
// Multi-channel LED PWM sequencer with button-driven mode FSM and hold/freeze.
//   state        | meaning
//   MODE_OFF     | all channels dark
//   MODE_BLINK   | all channels fully on for first half of the phase cycle
//   MODE_BREATHE | triangle-wave duty from phase
//   MODE_CHASE   | one channel (chase_idx) fully on, rotating
module led_pwm_sequencer
  import led_seq_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int LOG2DELAY     = 21,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic                clki,
  input  logic                rst_n,
  input  logic                btn_mode,
  input  logic                btn_hold,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [1:0]          mode,
  output logic                tick
);

  localparam int CIW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PWM_BITS:0] DUTY_FULL  = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [CIW-1:0]    CHASE_LAST = CIW'(CHANNELS - 1);

  mode_e                state_q;
  mode_e                state_d;
  logic                 mode_level;
  logic                 mode_press;
  logic                 hold_level;
  logic                 hold_press;
  logic                 unused_ok;
  logic [LOG2DELAY-1:0] presc;
  logic [PWM_BITS:0]    phase;
  logic [CIW-1:0]       chase_idx;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [PWM_BITS:0]    breathe_lvl;
  logic [PWM_BITS:0]    duty [CHANNELS];

  button_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_mode (
    .clki      (clki),
    .rst_n     (rst_n),
    .btn_raw   (btn_mode),
    .btn_state (mode_level),
    .press     (mode_press)
  );

  button_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_hold (
    .clki      (clki),
    .rst_n     (rst_n),
    .btn_raw   (btn_hold),
    .btn_state (hold_level),
    .press     (hold_press)
  );

  assign unused_ok = &{1'b0, mode_level, hold_press};

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n)
      state_q <= MODE_OFF;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mode_press)
      state_d = next_mode(state_q);
  end

  always_comb begin
    breathe_lvl = phase[PWM_BITS] ? {1'b0, ~phase[PWM_BITS-1:0]}
                                  : {1'b0, phase[PWM_BITS-1:0]};
    for (int i = 0; i < CHANNELS; i++) begin
      duty[i] = '0;
      case (state_q)
        MODE_BLINK:   duty[i] = phase[PWM_BITS] ? '0 : DUTY_FULL;
        MODE_BREATHE: duty[i] = breathe_lvl;
        MODE_CHASE:   duty[i] = (chase_idx == CIW'(i)) ? DUTY_FULL : '0;
        default:      duty[i] = '0;
      endcase
    end
  end

  assign mode = state_q;

  // hold_level is 1 while the hold button is released; low freezes prescaler and phase.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      tick      <= 1'b0;
      phase     <= '0;
      chase_idx <= '0;
      pwm_cnt   <= '0;
      pwm_out   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      tick    <= hold_level && (presc == '1);
      if (hold_level)
        presc <= presc + 1'b1;
      if (mode_press) begin
        phase     <= '0;
        chase_idx <= '0;
      end else if (tick && hold_level) begin
        phase <= phase + 1'b1;
        if (phase[PWM_BITS-1:0] == '1)
          chase_idx <= (chase_idx == CHASE_LAST) ? '0 : chase_idx + 1'b1;
      end
      for (int i = 0; i < CHANNELS; i++)
        pwm_out[i] <= ({1'b0, pwm_cnt} < duty[i]);
    end
  end

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Self-checking bench: directed and random button stimulus against a behavioural model.
module tb_led_pwm_sequencer;

  logic       clki;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_hold;
  logic [2:0] pwm_out;
  logic [1:0] mode;
  logic       tick;

  int vectors;
  int miscompares;
  string tag;

  // behavioural model state
  int m_s1, m_s2, m_st, m_run, m_press;
  int h_s1, h_s2, h_st, h_run, h_press;
  int presc, mtick, phase, chase, mmode, pcnt;
  logic [2:0] exp_pwm;

  led_pwm_sequencer #(
    .CHANNELS(3), .PWM_BITS(3), .LOG2DELAY(2), .DEBOUNCE_BITS(2)
  ) dut (
    .clki(clki), .rst_n(rst_n), .btn_mode(btn_mode), .btn_hold(btn_hold),
    .pwm_out(pwm_out), .mode(mode), .tick(tick)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_st = 1; m_run = 0; m_press = 0;
    h_s1 = 1; h_s2 = 1; h_st = 1; h_run = 0; h_press = 0;
    presc = 0; mtick = 0; phase = 0; chase = 0; mmode = 0; pcnt = 0;
    exp_pwm = 3'b000;
  endtask

  // Duty in 0..8 from the mode rules, 8 meaning always on.
  function automatic int duty(input int ch);
    case (mmode)
      1:       duty = (phase < 8) ? 8 : 0;
      2:       duty = (phase < 8) ? phase : 15 - phase;
      3:       duty = (ch == chase) ? 8 : 0;
      default: duty = 0;
    endcase
  endfunction

  // Stable level flips after 4 consecutive cycles of disagreement.
  task automatic deb(input int s2, inout int st, inout int run, output int pr);
    pr = 0;
    if (s2 != st) begin
      run++;
      if (run == 4) begin
        st  = s2;
        pr  = (s2 == 0) ? 1 : 0;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic model_step();
    int nt;
    logic [2:0] np;
    for (int ch = 0; ch < 3; ch++) np[ch] = (pcnt < duty(ch));
    nt = (presc == 3 && h_st == 1) ? 1 : 0;
    if (m_press == 1) begin
      mmode = (mmode + 1) % 4;
      phase = 0;
      chase = 0;
    end else if (mtick == 1 && h_st == 1) begin
      if (phase % 8 == 7) chase = (chase + 1) % 3;
      phase = (phase + 1) % 16;
    end
    if (h_st == 1) presc = (presc + 1) % 4;
    mtick = nt;
    exp_pwm = np;
    pcnt = (pcnt + 1) % 8;
    deb(m_s2, m_st, m_run, m_press);
    m_s2 = m_s1; m_s1 = int'(btn_mode);
    deb(h_s2, h_st, h_run, h_press);
    h_s2 = h_s1; h_s1 = int'(btn_hold);
  endtask

  task automatic check_model();
    vectors++;
    assert ({mode, pwm_out, tick} === {mmode[1:0], exp_pwm, mtick[0]})
    else begin
      miscompares++;
      $error("FAIL %s: observed mode=%0d pwm=%b tick=%b expected mode=%0d pwm=%b tick=%b",
             tag, mode, pwm_out, tick, mmode, exp_pwm, mtick);
    end
  endtask

  task automatic check_int(input string name, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", name, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clki);
    #1;
    if (rst_n) model_step();
    else model_reset();
    check_model();
  endtask

  task automatic run(input int n, output int ticks, output int highs);
    ticks = 0;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (tick) ticks++;
      if (pwm_out[0]) highs++;
    end
  endtask

  task automatic press_mode();
    int t, h;
    btn_mode = 1'b0;
    run(8, t, h);
    btn_mode = 1'b1;
    run(8, t, h);
  endtask

  initial begin
    int t, h;
    vectors = 0;
    miscompares = 0;
    btn_mode = 1'b1;
    btn_hold = 1'b1;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    tag = "reset_state";
    check_model();
    run(2, t, h);
    rst_n = 1'b1;

    tag = "idle";
    run(100, t, h);
    check_int("idle_tick_count", t, 25);
    check_int("idle_pwm_high", h, 0);

    tag = "bounce";
    btn_mode = 1'b0; run(3, t, h);
    btn_mode = 1'b1; run(1, t, h);
    btn_mode = 1'b0; run(2, t, h);
    btn_mode = 1'b1; run(12, t, h);
    check_int("bounce_no_mode_change", int'(mode), 0);

    tag = "press_blink";
    press_mode();
    check_int("press_to_blink", int'(mode), 1);
    run(20, t, h);
    tag = "blink";
    run(64, t, h);
    check_int("blink_half_on", h, 32);
    check_int("blink_mode_stable", int'(mode), 1);

    tag = "breathe";
    press_mode();
    check_int("press_to_breathe", int'(mode), 2);
    run(200, t, h);

    tag = "hold";
    btn_hold = 1'b0;
    run(12, t, h);
    run(40, t, h);
    check_int("hold_no_ticks", t, 0);
    press_mode();
    check_int("press_during_hold", int'(mode), 3);
    btn_hold = 1'b1;
    tag = "chase";
    run(150, t, h);

    tag = "random";
    for (int s = 0; s < 60; s++) begin
      btn_mode = 1'($urandom_range(0, 1));
      btn_hold = ($urandom_range(0, 3) != 0);
      run($urandom_range(1, 12), t, h);
    end
    btn_mode = 1'b1;
    btn_hold = 1'b1;
    run(10, t, h);

    tag = "mid_reset";
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_int("reset_pwm_immediate", int'(pwm_out), 0);
    check_int("reset_mode_immediate", int'(mode), 0);
    check_int("reset_tick_immediate", int'(tick), 0);
    run(3, t, h);
    rst_n = 1'b1;

    tag = "post_reset_random";
    for (int s = 0; s < 40; s++) begin
      btn_mode = 1'($urandom_range(0, 1));
      btn_hold = ($urandom_range(0, 4) != 0);
      run($urandom_range(1, 12), t, h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pwm_sequencer.md
Name: led_pwm_sequencer

Overview:
Parametrised multi-channel LED sequencer: per-channel PWM outputs driven by a mode state machine (OFF / BLINK / BREATHE / CHASE).
Mode advances on debounced button presses; a second button freezes the animation.
Outputs feed the PWM inputs of the SB_RGBA_DRV hard LED driver and, for scope monitoring, the pmod header.

Parameters:
CHANNELS, 3, number of PWM output channels (>=2)
PWM_BITS, 8, PWM counter width; duty resolution 2**PWM_BITS
LOG2DELAY, 21, prescaler width; one animation tick every 2**LOG2DELAY clocks
DEBOUNCE_BITS, 16, button must be stable 2**DEBOUNCE_BITS clocks to register

Ports:
clki  in  1  system clock, via global buffer
rst_n  in  1  asynchronous active-low reset
btn_mode  in  1  raw mode button, active-low (pulled up), asynchronous
btn_hold  in  1  raw hold button, active-low (pulled up), asynchronous
pwm_out  out  CHANNELS  per-channel PWM, active-high
mode  out  2  current mode: 0 OFF, 1 BLINK, 2 BREATHE, 3 CHASE
tick  out  1  one-clock pulse per animation tick

Behaviour:
- Reset (async assert, sync release): mode=OFF, pwm_out=0, tick=0, prescaler=0, phase=0, chase_idx=0, pwm_cnt=0, debounced button states=1 (released).
- Buttons: 2-flop synchroniser, then debounce counter. Stable state takes the raw value after 2**DEBOUNCE_BITS consecutive differing cycles; any bounce clears the counter. Press event = debounced mode button 1->0, one-clock pulse.
- Prescaler: LOG2DELAY-bit free-running counter. Tick = registered pulse when prescaler is all-ones and hold is not asserted (debounced btn_hold=1). When held, prescaler and phase freeze; pwm_cnt keeps running.
- phase: PWM_BITS+1 bits, +1 per tick, wraps modulo 2**(PWM_BITS+1).
- chase_idx: 0..CHANNELS-1. Advances on a tick where phase[PWM_BITS-1:0] wraps to 0; wraps CHANNELS-1 -> 0 (no power-of-2 assumption).
- Mode FSM: press advances OFF->BLINK->BREATHE->CHASE->OFF. On the clock after a press: mode updates, phase=0, chase_idx=0. Prescaler is not reset.
- Press and tick in the same cycle: the press wins; phase=0, no increment.
- Duty (PWM_BITS+1 bits; FULL = 2**PWM_BITS means always on), same for all channels unless stated:
  - OFF: 0.
  - BLINK: FULL when phase[PWM_BITS]=0, else 0.
  - BREATHE: phase[PWM_BITS]=0 ? phase[PWM_BITS-1:0] : ~phase[PWM_BITS-1:0] (triangle wave, 0 .. 2**PWM_BITS-1).
  - CHASE: channel chase_idx = FULL, all others 0.
- PWM: pwm_cnt is a PWM_BITS-bit free-running counter. pwm_out[i] is registered = (pwm_cnt < duty[i]), giving one clock latency from duty to output. Duty 0 -> constant 0; FULL -> constant 1.
- mode output is the registered FSM state. tick is registered.
- Reset mid-operation immediately forces all reset values; no partial PWM period is completed.

Decomposition:
- Package led_seq_pkg: mode enum (MODE_OFF, MODE_BLINK, MODE_BREATHE, MODE_CHASE, 2 bits) and a next-mode function.
- Sub-module button_debounce (parameter DEBOUNCE_BITS; ports clki, rst_n, btn_raw, btn_state, press). Instantiated twice.

Test Plan (CHANNELS=3, PWM_BITS=3, LOG2DELAY=2, DEBOUNCE_BITS=2):
- Reset then idle 100 clocks -> mode=0, pwm_out=3'b000, tick pulses every 4 clocks.
- btn_mode low for 3 clocks with bounce then release -> no mode change. Low for >=6 clocks -> mode=1 exactly once per press.
- mode=BLINK -> pwm_out=3'b111 for phase 0..7 (32 clocks), 3'b000 for the next 32 clocks, repeating.
- mode=BREATHE, phase=3 -> each pwm_out high 3 of every 8 clocks. At phase=12 (8+4 -> ~4=3) -> 3 of 8 again.
- mode=CHASE -> pwm_out sequence 001, 010, 100, 001, each held 8 ticks (32 clocks).
- Assert btn_hold in BREATHE -> tick stops, duty constant. Press btn_mode during hold -> mode=CHASE, phase=0. Assert rst_n=0 mid-period -> pwm_out=0 in the same cycle.
